rob_mc: RTL

- Parametrised successor to the single-commit reorder buffer in the commit stage.
- Generalises depth, number of CDB writeback ports and commit width (1 or 2 retirements per cycle).
- Sits between ID (issue, operand lookup), the regfile (architectural write), SLB (store release), BP (branch feedback) and IF (rollback PC).
- Rollback on branch mispredict or JALR flushes every entry.

---
 rtl/rob_mc.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer: CDB capture, operand lookup, 1/2-wide retire, rollback.
// Define ROB_PERF_CNT_EN to add the perf_commit_cnt/perf_rb_cnt/perf_full_cyc counters.
`ifndef ROB_IDX_LN
`define ROB_IDX_LN 4
`endif
`ifndef INST_OPT_TP
`define INST_OPT_TP logic [5:0]
`endif

module rob_mc #(
    parameter int ROB_BIT     = `ROB_IDX_LN,
    parameter int CDB_N       = 2,
    parameter int CMT_W       = 2,
    parameter int FULL_MARGIN = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rob_st,
    output logic                      rob_full,
    output logic                      rob_empty,
    output logic [ROB_BIT-1:0]        rob_idx,
    output logic                      rob_rb_ena,
    output logic [31:0]               if_rb_pc,
    input  logic                      id_valid,
    input  `INST_OPT_TP               id_opt,
    input  logic [4:0]                id_dest,
    input  logic [31:0]               id_data,
    input  logic [31:0]               id_cur_pc,
    input  logic [31:0]               id_mis_pc,
    input  logic                      id_pb_tk,
    input  logic [ROB_BIT-1:0]        id_src1,
    input  logic [ROB_BIT-1:0]        id_src2,
    output logic                      id_src1_rdy,
    output logic                      id_src2_rdy,
    output logic [31:0]               id_val1,
    output logic [31:0]               id_val2,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N-1:0]          cdb_tk,
    input  logic [CDB_N*ROB_BIT-1:0]  cdb_src,
    input  logic [CDB_N*32-1:0]       cdb_val,
    input  logic [ROB_BIT-1:0]        slb_st_idx,
    input  logic                      slb_st_rdy,
    output logic                      slb_commit_rdy,
    output logic [CMT_W-1:0]          reg_wr_ena,
    output logic [CMT_W*5-1:0]        reg_wr_rd,
    output logic [CMT_W*32-1:0]       reg_wr_val,
    output logic [CMT_W*ROB_BIT-1:0]  reg_wr_idx,
    output logic                      bp_fb_ena,
    output logic                      bp_fb_tk,
    output logic [31:0]               bp_fb_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]               perf_commit_cnt,
    output logic [31:0]               perf_rb_cnt,
    output logic [31:0]               perf_full_cyc
`endif
);

    localparam int DEPTH   = 2**ROB_BIT;
    localparam int USABLE  = DEPTH - 1;
    localparam int CW      = ROB_BIT + 1;
    localparam int FULL_TH = USABLE - FULL_MARGIN;

    localparam logic [5:0] OPT_BEQ  = 6'd20;
    localparam logic [5:0] OPT_BGEU = 6'd25;
    localparam logic [5:0] OPT_SB   = 6'd26;
    localparam logic [5:0] OPT_SW   = 6'd28;
    localparam logic [5:0] OPT_JALR = 6'd29;

    typedef logic [ROB_BIT-1:0] idx_t;

    function automatic idx_t nxt(input idx_t i);
        return (i == idx_t'(DEPTH-1)) ? idx_t'(1) : i + idx_t'(1);
    endfunction

    function automatic logic is_br(input `INST_OPT_TP o);
        return (o >= OPT_BEQ) && (o <= OPT_BGEU);
    endfunction

    function automatic logic is_st(input `INST_OPT_TP o);
        return (o >= OPT_SB) && (o <= OPT_SW);
    endfunction

    logic [DEPTH-1:0] inque_q, busy_q, rltk_q, pbtk_q;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      cpc_q  [DEPTH];
    logic [31:0]      mpc_q  [DEPTH];
    `INST_OPT_TP      opt_q  [DEPTH];
    logic [4:0]       dest_q [DEPTH];

    idx_t            head_q, tail_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rb_q, rbh_q, rb_now;
    logic [31:0]     rbpc_q;
    logic [1:0]      wen_q;
    logic [1:0][4:0] wrd_q;
    logic [1:0][31:0] wval_q;
    logic [1:0][ROB_BIT-1:0] widx_q;
    logic            fben_q, fbtk_q;
    logic [31:0]     fbpc_q;

    idx_t       h0, h1, h2;
    logic       br0, st0, jr0, br1, st1, jr1;
    logic       ret0, ret1, push;
    logic [1:0] npop;

    assign rb_now = rb_q | rbh_q;

    always_comb begin
        h0   = head_q;
        h1   = nxt(head_q);
        h2   = nxt(h1);
        br0  = is_br(opt_q[h0]);
        st0  = is_st(opt_q[h0]);
        jr0  = (opt_q[h0] == OPT_JALR);
        br1  = is_br(opt_q[h1]);
        st1  = is_st(opt_q[h1]);
        jr1  = (opt_q[h1] == OPT_JALR);
        ret0 = 1'b0;
        ret1 = 1'b0;
        if (!rob_st && cnt_q != '0) begin
            ret0 = st0 ? (slb_st_rdy && slb_st_idx == h0) : !busy_q[h0];
        end
        // A second retire only pairs two plain register-writing ops.
        if (CMT_W == 2) begin
            ret1 = ret0 && !(br0 || st0 || jr0) && inque_q[h1]
                && !busy_q[h1] && !(br1 || st1 || jr1);
        end
        push  = id_valid && !rob_st;
        npop  = {1'b0, ret0} + {1'b0, ret1};
        cnt_d = cnt_q + CW'(push) - CW'(npop);
    end

    function automatic logic [32:0] lookup(input idx_t s);
        logic [32:0] r;
        r = {inque_q[s] && !busy_q[s], data_q[s]};
        for (int p = CDB_N-1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_src[p*ROB_BIT +: ROB_BIT] == s) begin
                r = {1'b1, cdb_val[p*32 +: 32]};
            end
        end
        if (s == '0) r = {1'b1, 32'd0};
        return r;
    endfunction

    assign {id_src1_rdy, id_val1} = lookup(id_src1);
    assign {id_src2_rdy, id_val2} = lookup(id_src2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= idx_t'(1);
            tail_q  <= idx_t'(1);
            cnt_q   <= '0;
            inque_q <= '0;
            busy_q  <= '0;
            rb_q    <= 1'b0;
            rbh_q   <= 1'b0;
            rbpc_q  <= '0;
            wen_q   <= '0;
            wrd_q   <= '0;
            wval_q  <= '0;
            widx_q  <= '0;
            fben_q  <= 1'b0;
            fbtk_q  <= 1'b0;
            fbpc_q  <= '0;
        end else begin
            rb_q   <= 1'b0;
            wen_q  <= '0;
            fben_q <= 1'b0;
            if (!rdy) begin
                // A stalled pipeline must not lose a pending flush.
                if (rb_q) rbh_q <= 1'b1;
            end else if (rb_now) begin
                rbh_q   <= 1'b0;
                head_q  <= idx_t'(1);
                tail_q  <= idx_t'(1);
                cnt_q   <= '0;
                inque_q <= '0;
                busy_q  <= '0;
            end else begin
                for (int p = 0; p < CDB_N; p++) begin
                    if (cdb_valid[p]) busy_q[cdb_src[p*ROB_BIT +: ROB_BIT]] <= 1'b0;
                end
                if (ret0) begin
                    inque_q[h0] <= 1'b0;
                    widx_q[0]   <= h0;
                    if (br0) begin
                        fben_q <= 1'b1;
                        fbtk_q <= rltk_q[h0];
                        fbpc_q <= cpc_q[h0];
                        if (rltk_q[h0] != pbtk_q[h0]) begin
                            rb_q   <= 1'b1;
                            rbpc_q <= mpc_q[h0];
                        end
                    end else if (jr0) begin
                        rb_q   <= 1'b1;
                        rbpc_q <= {data_q[h0][31:1], 1'b0};
                        if (dest_q[h0] != '0) begin
                            wen_q[0]  <= 1'b1;
                            wrd_q[0]  <= dest_q[h0];
                            wval_q[0] <= cpc_q[h0] + 32'd4;
                        end
                    end else if (!st0 && dest_q[h0] != '0) begin
                        wen_q[0]  <= 1'b1;
                        wrd_q[0]  <= dest_q[h0];
                        wval_q[0] <= data_q[h0];
                    end
                end
                if (ret1) begin
                    inque_q[h1] <= 1'b0;
                    widx_q[1]   <= h1;
                    if (dest_q[h1] != '0) begin
                        wen_q[1]  <= 1'b1;
                        wrd_q[1]  <= dest_q[h1];
                        wval_q[1] <= data_q[h1];
                    end
                end
                if (push) begin
                    inque_q[tail_q] <= 1'b1;
                    busy_q[tail_q]  <= 1'b1;
                    tail_q          <= nxt(tail_q);
                end
                head_q <= ret1 ? h2 : (ret0 ? h1 : h0);
                cnt_q  <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !rb_now) begin
            for (int p = 0; p < CDB_N; p++) begin
                if (cdb_valid[p]) begin
                    data_q[cdb_src[p*ROB_BIT +: ROB_BIT]] <= cdb_val[p*32 +: 32];
                    rltk_q[cdb_src[p*ROB_BIT +: ROB_BIT]] <= cdb_tk[p];
                end
            end
            if (push) begin
                opt_q[tail_q]  <= id_opt;
                dest_q[tail_q] <= id_dest;
                data_q[tail_q] <= id_data;
                cpc_q[tail_q]  <= id_cur_pc;
                mpc_q[tail_q]  <= id_mis_pc;
                pbtk_q[tail_q] <= id_pb_tk;
                rltk_q[tail_q] <= 1'b0;
            end
        end
    end

    assign rob_full       = (cnt_q >= CW'(FULL_TH));
    assign rob_empty      = (cnt_q == '0);
    assign rob_idx        = tail_q;
    assign rob_rb_ena     = rb_q;
    assign if_rb_pc       = rbpc_q;
    assign slb_commit_rdy = inque_q[slb_st_idx] && (slb_st_idx == head_q);
    assign reg_wr_ena     = wen_q[CMT_W-1:0];
    assign reg_wr_rd      = wrd_q[CMT_W-1:0];
    assign reg_wr_val     = wval_q[CMT_W-1:0];
    assign reg_wr_idx     = widx_q[CMT_W-1:0];
    assign bp_fb_ena      = fben_q;
    assign bp_fb_tk       = fbtk_q;
    assign bp_fb_pc       = fbpc_q;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] pcmt_q, prb_q, pfull_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcmt_q  <= '0;
            prb_q   <= '0;
            pfull_q <= '0;
        end else if (rdy) begin
            if (rb_now) prb_q <= prb_q + 32'd1;
            else        pcmt_q <= pcmt_q + 32'(npop);
            if (rob_full) pfull_q <= pfull_q + 32'd1;
        end
    end

    assign perf_commit_cnt = pcmt_q;
    assign perf_rb_cnt     = prb_q;
    assign perf_full_cyc   = pfull_q;
`endif

endmodule
